// File: rtl/core_wb_queue_if.sv
// Writeback line type and the producer/writeback handshake interface for core_wb_queue.
// master = execution unit plus arbiter side, slave = the queue.
package core_wb_pkg;
  typedef struct packed {
    logic        ready;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_line;
endpackage

interface core_wb_queue_if;
  import core_wb_pkg::*;

  logic   in_valid;
  wb_line in_line;
  logic   in_ready;
  wb_line wb;
  logic   wb_stall;

  modport master (output in_valid, output in_line, input in_ready,
                  input wb, output wb_stall);
  modport slave  (input in_valid, input in_line, output in_ready,
                  output wb, input wb_stall);
endinterface

// File: rtl/core_wb_queue.sv
// Producer-side writeback FIFO presenting its head as a wb_line to core_writeback.
// Optional same-cycle empty-queue bypass enabled by defining CORE_WBQ_BYPASS_EN.
module core_wb_queue
  import core_wb_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CNT_BITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  core_wb_queue_if.slave      bus,
  output logic [CNT_BITS-1:0] count,
  output logic                overflow
);
  localparam int unsigned PTR_BITS = $clog2(DEPTH);

  wb_line              mem [DEPTH];
  logic [PTR_BITS-1:0] head;
  logic [PTR_BITS-1:0] tail;
  logic [CNT_BITS-1:0] cnt;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                bypass_take;
  wb_line              wb_out;

  assign full  = (cnt == CNT_BITS'(DEPTH));
  assign empty = (cnt == '0);

`ifdef CORE_WBQ_BYPASS_EN
  // Reset and flush both suppress the bypass candidate.
  assign bypass_take = empty && bus.in_valid && !flush && !rst_n;
`else
  assign bypass_take = 1'b0;
`endif

  always_comb begin
    wb_out = '0;
    if (!empty) begin
      wb_out       = mem[head];
      wb_out.ready = 1'b1;
    end else if (bypass_take) begin
      wb_out       = bus.in_line;
      wb_out.ready = 1'b1;
    end
  end

  // A bypassed result consumed this cycle must not also be enqueued.
  assign pop  = !empty && !bus.wb_stall;
  assign push = bus.in_valid && !full && !(bypass_take && !bus.wb_stall);

  assign bus.wb       = wb_out;
  assign bus.in_ready = !full;
  assign count        = cnt;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (bus.in_valid && full)
        overflow <= 1'b1;
      if (flush) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        if (push)
          tail <= tail + PTR_BITS'(1);
        if (pop)
          head <= head + PTR_BITS'(1);
        cnt <= cnt + CNT_BITS'(push) - CNT_BITS'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n && !flush && push)
      mem[tail] <= bus.in_line;
  end
endmodule

// File: tb/tb_core_wb_queue.sv
// Self-checking bench for core_wb_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_core_wb_queue;
  import core_wb_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef CORE_WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [2:0] count;
  logic       overflow;

  core_wb_queue_if bus ();

  core_wb_queue #(.DEPTH(DEPTH), .CNT_BITS(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus.slave),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents of the queue plus sticky overflow.
  wb_line mq[$];
  bit     m_ovf;
  bit     started = 1'b0;

  always @(negedge clk) begin
    wb_line exp_wb;
    bit     bypassed;
    bit     do_push;
    if (started) begin
      exp_wb = '0;
      if (mq.size() > 0) exp_wb = mq[0];
      else if (BYP && bus.in_valid && !flush && !rst_n) begin
        exp_wb = bus.in_line;
        exp_wb.ready = 1'b1;
      end
      check("cyc_count", 64'(count), 64'(mq.size()));
      check("cyc_in_ready", 64'(bus.in_ready), 64'(mq.size() < DEPTH));
      check("cyc_overflow", 64'(overflow), 64'(m_ovf));
      check("cyc_wb", 64'(bus.wb), 64'(exp_wb));
    end
    // Advance the model using inputs that stay stable until the next posedge.
    if (rst_n) begin
      mq.delete();
      m_ovf   = 1'b0;
      started = 1'b1;
    end else if (started) begin
      if (bus.in_valid && mq.size() == DEPTH) m_ovf = 1'b1;
      if (flush) mq.delete();
      else begin
        bypassed = BYP && mq.size() == 0 && bus.in_valid && !bus.wb_stall;
        do_push  = bus.in_valid && mq.size() < DEPTH && !bypassed;
        if (mq.size() > 0 && !bus.wb_stall) void'(mq.pop_front());
        if (do_push) begin
          wb_line e;
          e = bus.in_line;
          e.ready = 1'b1;
          mq.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [4:0] rd, input logic [31:0] data);
    bus.in_valid = 1'b1;
    bus.in_line  = '{ready: 1'b0, rd: rd, data: data};
    tick();
  endtask

  initial begin
    logic [2:0] stall_pat [5];
    stall_pat = '{3'd1, 3'd1, 3'd0, 3'd1, 3'd0};
    rst_n = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b1; bus.in_line = '{ready: 1'b1, rd: 5'd9, data: 32'hdead_beef};
    bus.wb_stall = 1'b0;
    tick(); tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_wb_ready", 64'(bus.wb.ready), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_overflow", 64'(overflow), 64'd0);
    rst_n = 1'b0; bus.in_valid = 1'b0;
    tick();

    // Fill under stall, then overflow attempt.
    bus.wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) put(5'(i), 32'(8'h11 * i));
    bus.in_valid = 1'b0;
    check("fill_count", 64'(count), 64'd4);
    check("fill_in_ready", 64'(bus.in_ready), 64'd0);
    check("fill_head_rd", 64'(bus.wb.rd), 64'd1);
    check("fill_head_data", 64'(bus.wb.data), 64'h11);
    put(5'd5, 32'h55);
    bus.in_valid = 1'b0;
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_count", 64'(count), 64'd4);
    tick();
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("ovf_head_rd", 64'(bus.wb.rd), 64'd1);

    // Drain in order.
    bus.wb_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check("drain_ready", 64'(bus.wb.ready), 64'd1);
      check("drain_rd", 64'(bus.wb.rd), 64'(i));
      check("drain_data", 64'(bus.wb.data), 64'(8'h11 * i));
      tick();
    end
    check("drain_empty_ready", 64'(bus.wb.ready), 64'd0);
    check("drain_empty_payload", 64'(bus.wb), 64'd0);
    check("drain_ovf_kept", 64'(overflow), 64'd1);

    // Streaming with no stall.
    for (int i = 0; i < 10; i++) begin
      put(5'(i + 8), $urandom);
      check("stream_count", 64'(count), BYP ? 64'd0 : 64'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("stream_done", 64'(count), 64'd0);

    // Flush with a concurrent push.
    bus.wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) put(5'(20 + i), $urandom);
    flush = 1'b1;
    put(5'd30, 32'h3030);
    flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_ready", 64'(bus.wb.ready), 64'd0);
    check("flush_ovf_kept", 64'(overflow), 64'd1);

    // Stall hold with two entries.
    put(5'd1, 32'haaaa);
    put(5'd2, 32'hbbbb);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.wb_stall = stall_pat[i][0];
      tick();
    end
    check("hold_count", 64'(count), 64'd0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      rst_n        = ($urandom_range(0, 199) == 0);
      flush        = ($urandom_range(0, 49) == 0);
      bus.in_valid = $urandom_range(0, 2) != 0;
      bus.wb_stall = $urandom_range(0, 9) < 5;
      bus.in_line  = '{ready: 1'($urandom), rd: 5'($urandom), data: $urandom};
      tick();
    end
    rst_n = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
